// File: rtl/serial_receiver_if.sv
// Signal bundle for serial_receiver: bit-serial input side plus the valid/ready word output.
// The receiver takes the slave modport; the serial source / word consumer takes master.
interface serial_receiver_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic             serial_in;
    logic             bit_valid;
    logic             start;
    logic             word_ready;
    logic             overrun_clr;
    logic [WIDTH-1:0] Q;
    logic             word_valid;
    logic             busy;
    logic [CntW-1:0]  bit_count;
    logic             overrun;
    logic             parity_err;

    modport master (
        output serial_in, bit_valid, start, word_ready, overrun_clr,
        input  Q, word_valid, busy, bit_count, overrun, parity_err
    );

    modport slave (
        input  serial_in, bit_valid, start, word_ready, overrun_clr,
        output Q, word_valid, busy, bit_count, overrun, parity_err
    );
endinterface

// File: rtl/serial_receiver.sv
// Double-buffered serial-to-parallel receiver with sticky overrun flag.
// Define SERIAL_RX_PARITY_EN to expect a trailing even-parity bit per frame.
module serial_receiver #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input logic              clock,
    input logic              clear_n,
    serial_receiver_if.slave rx
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef SERIAL_RX_PARITY_EN
    localparam int unsigned FrameLen = WIDTH + 1;
`else
    localparam int unsigned FrameLen = WIDTH;
`endif
    localparam logic [CntW-1:0] LastIdx = CntW'(FrameLen - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             ov_q, ov_d;
    logic             ov_set;
    logic             done;
    logic [WIDTH-1:0] word;
`ifdef SERIAL_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
    logic             bad;
`endif

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST != 0) return {cur[WIDTH-2:0], b};
        else                return {b, cur[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done    = 1'b0;
        word    = shift_q;
`ifdef SERIAL_RX_PARITY_EN
        par_d   = par_q;
        bad     = 1'b0;
`endif
        // The final bit belongs to the running frame even if start coincides with it;
        // start then opens a fresh frame right behind the completed one.
        if (state_q == StShift && rx.bit_valid && cnt_q == LastIdx) begin
            done    = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            bad     = par_q ^ rx.serial_in;
            par_d   = 1'b0;
`else
            word    = shift_in(shift_q, rx.serial_in);
`endif
            state_d = rx.start ? StShift : StIdle;
            cnt_d   = '0;
        end else if (rx.start) begin
            state_d = StShift;
            cnt_d   = rx.bit_valid ? CntW'(1) : '0;
            if (rx.bit_valid) shift_d = shift_in(shift_q, rx.serial_in);
`ifdef SERIAL_RX_PARITY_EN
            par_d   = rx.bit_valid & rx.serial_in;
`endif
        end else if (state_q == StShift && rx.bit_valid) begin
            cnt_d   = cnt_q + CntW'(1);
            shift_d = shift_in(shift_q, rx.serial_in);
`ifdef SERIAL_RX_PARITY_EN
            par_d   = par_q ^ rx.serial_in;
`endif
        end
    end

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        ov_set  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (done) begin
            if (!valid_q || rx.word_ready) begin
                q_d     = word;
                valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                perr_d  = bad;
`endif
            end else begin
                ov_set  = 1'b1;
            end
        end else if (rx.word_ready) begin
            valid_d = 1'b0;
        end
        ov_d = ov_set | (ov_q & ~rx.overrun_clr);
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ov_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ov_q    <= ov_d;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx.Q          = q_q;
    assign rx.word_valid = valid_q;
    assign rx.busy       = (state_q == StShift);
    assign rx.bit_count  = cnt_q;
    assign rx.overrun    = ov_q;
`ifdef SERIAL_RX_PARITY_EN
    assign rx.parity_err = perr_q;
`else
    assign rx.parity_err = 1'b0;
`endif
endmodule

// File: doc/serial_receiver.md
# serial_receiver

- Serial-to-parallel receiver: the receive end of the bit-serial link driven by the library's parallel-load `shift_register`.
- Frames `WIDTH` data bits, qualified by a bit strobe, into a parallel word and presents it on a valid/ready output.
- Double-buffered: a word is held for the consumer while the next frame shifts in.
- Overrun and optional parity errors are flagged.

## Interface
- `WIDTH`, 8: data bits per frame (≥2).
- `MSB_FIRST`, 1: 1 means the first received bit lands in `Q[WIDTH-1]`; 0 means the first bit lands in `Q[0]`.
- `clock`  in  1  system clock; all state changes on posedge.
- `clear_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `serial_in`  in  1  data bit, sampled only when `bit_valid`=1.
- `bit_valid`  in  1  strobe: `serial_in` carries a bit this cycle.
- `start`  in  1  frame sync; marks the beginning of a frame.
- `word_ready`  in  1  consumer accepts `Q` this cycle.
- `overrun_clr`  in  1  clears sticky `overrun`.
- `Q`  out  WIDTH  received word (output buffer).
- `word_valid`  out  1  `Q` holds an unaccepted word.
- `busy`  out  1  a frame is in progress (state SHIFT).
- `bit_count`  out  $clog2(WIDTH+1)  bits captured in the current frame.
- `overrun`  out  1  sticky: a completed word was dropped.
- `parity_err`  out  1  parity of the word in `Q` is bad; qualified by `word_valid`.

## Operation
- States: IDLE and SHIFT.
  - IDLE: `start` → SHIFT with `bit_count`=0. Otherwise `bit_valid` is ignored.
  - SHIFT: each `bit_valid` shifts `serial_in` into the internal shift register and increments `bit_count`.
- Shift direction:
  - `MSB_FIRST`=1: the register shifts left and the new bit enters bit 0.
  - `MSB_FIRST`=0: the register shifts right and the new bit enters bit `WIDTH-1`.
- Same-cycle `start` and `bit_valid`: that bit is bit 0 of the frame, so `bit_count` becomes 1.
- `start` while in SHIFT: the partial frame is discarded and a new frame begins. This applies the same rule, including a same-cycle bit.
- Frame completion: the last bit is captured (the `WIDTH`th bit, or the parity bit when configured).
  - The word transfers to the output buffer `Q`.
  - The state returns to IDLE and `bit_count` returns to 0.
- Output handshake: `word_valid` stays high and `Q` is stable until a cycle with `word_ready`=1, which clears `word_valid`.
  - `word_ready` while `word_valid`=0 has no effect.
- Completion while `word_valid`=1 and `word_ready`=0:
  - The new word is dropped; `Q` keeps the old word.
  - `overrun` is set to 1.
- Completion in the same cycle as acceptance: the new word loads into `Q` and `word_valid` remains 1. There is no overrun.
- `overrun` clears only on `overrun_clr` or reset. If a set and `overrun_clr` occur in the same cycle, the set wins.
- `bit_count` wraps nowhere: it never exceeds `WIDTH` (`WIDTH`+1 with parity) before returning to 0.

## Timing
- Reset values, and effect of `clear_n`=0 on posedge:
  - State is IDLE; `Q`=0.
  - `word_valid`=0, `busy`=0, `bit_count`=0, `overrun`=0, `parity_err`=0.
  - Reset mid-frame discards the partial frame.
- Latency: `word_valid` and the new `Q` appear on the posedge after the cycle in which the last bit's `bit_valid` is sampled.
- `busy` rises the cycle after `start` and falls the cycle after the final bit.
- Back-to-back frames: `start` may coincide with the completion cycle of the previous frame. It takes effect after the completion, so both words are delivered.
- Throughput: one bit per clock maximum; `bit_valid` may be held high continuously.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - Each frame carries one extra bit after the data bits: even parity over data plus parity.
  - Frame length is `WIDTH`+1 strobed bits; the parity bit is not stored in `Q`.
  - `parity_err` is loaded together with `Q`, set to 1 on a mismatch. A bad word is still delivered.
- `SERIAL_RX_PARITY_EN` undefined:
  - Frames are `WIDTH` bits.
  - `parity_err` is tied to 0.

## Test plan
- `WIDTH`=8, `MSB_FIRST`=1: `start`+`bit_valid` with bits 1,0,1,0,0,1,0,1 on consecutive cycles → next cycle `Q`=8'hA5, `word_valid`=1, `busy`=0.
- `MSB_FIRST`=0, same bit stream → `Q`=8'hA5 bit-reversed = 8'hA5 (palindrome). Then stream 1,1,0,0,0,0,0,0 → `Q`=8'h03.
- Hold `word_ready`=0, send two full frames → `Q` keeps the first word and `overrun`=1. `overrun_clr` → `overrun`=0.
- Send 3 bits, then `start` with bits 8'hFF → `Q`=8'hFF, and the partial bits never appear.
- Reset (`clear_n`=0) after 5 bits → all outputs at reset values. Then a full frame 8'h3C → `Q`=8'h3C.
- With `SERIAL_RX_PARITY_EN`: data 8'h01 with parity bit 1 → `parity_err`=0. Same data with parity bit 0 → `parity_err`=1 and `word_valid`=1.
